// File: rtl/jtcontra_layer_mix.sv
// Priority mixer for LAYERS pixel streams with an internal dual-port xBGR555
// palette; produces blank-gated RGB three pixel clocks after the inputs.
module jtcontra_layer_mix #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 6,
  parameter int PALW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   cpu_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic                   prio_rev,
  input  logic                   pal_cs,
  input  logic                   cpu_rnw,
  input  logic [PALW-1:0]        cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  output logic [4:0]             red,
  output logic [4:0]             green,
  output logic [4:0]             blue
);
  localparam int LW = $clog2(LAYERS);
  localparam int CW = LW + PXLW;

  logic [PXLW-1:0]   lyr [LAYERS];
  logic [LAYERS-1:0] opaque;
  logic [CW-1:0]     winner;

  logic [7:0]    palRam [2**PALW];
  logic [7:0]    palDout_q;

  logic [CW-1:0] colS1_q;
  logic          hbS1_q, vbS1_q;
  logic [7:0]    palLoS2_q, palHiS2_q;
  logic          hbS2_q, vbS2_q;
  logic [4:0]    red_d, green_d, blue_d;
  logic [4:0]    red_q, green_q, blue_q;
  logic          hbS3_q, vbS3_q;

  // Transparency is judged on the four colour bits only, upper index bits ignored
  always_comb begin
    opaque = '0;
    for (int k = 0; k < LAYERS; k++) begin
      lyr[k]    = pxl[k*PXLW +: PXLW];
      opaque[k] = gfx_en[k] & (|lyr[k][3:0]);
    end
  end

  // Scan from the lowest to the highest priority layer so the top opaque one wins
  always_comb begin
    winner = {LW'(LAYERS-1), PXLW'(0)};
    for (int i = 0; i < LAYERS; i++) begin
      if (prio_rev) begin
        if (opaque[i]) winner = {LW'(i), lyr[i]};
      end else if (opaque[LAYERS-1-i]) begin
        winner = {LW'(LAYERS-1-i), lyr[LAYERS-1-i]};
      end
    end
  end

  // Palette storage is deliberately not reset so CPU-loaded colours survive rst
  always_ff @(posedge clk) begin
    if (pal_cs && !cpu_rnw && cpu_cen) palRam[cpu_addr] <= cpu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) palDout_q <= '0;
    else     palDout_q <= palRam[cpu_addr];
  end

  always_comb begin
    red_d   = palLoS2_q[4:0];
    green_d = {palHiS2_q[1:0], palLoS2_q[7:5]};
    blue_d  = palHiS2_q[6:2];
    if (!(hbS2_q && vbS2_q)) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // Three-stage pixel pipeline: select, palette fetch, blank-gated colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colS1_q   <= '0;
      hbS1_q    <= 1'b0;
      vbS1_q    <= 1'b0;
      palLoS2_q <= '0;
      palHiS2_q <= '0;
      hbS2_q    <= 1'b0;
      vbS2_q    <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hbS3_q    <= 1'b0;
      vbS3_q    <= 1'b0;
    end else if (pxl_cen) begin
      colS1_q   <= winner;
      hbS1_q    <= LHBL;
      vbS1_q    <= LVBL;
      palLoS2_q <= palRam[{colS1_q, 1'b0}];
      palHiS2_q <= palRam[{colS1_q, 1'b1}];
      hbS2_q    <= hbS1_q;
      vbS2_q    <= vbS1_q;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      hbS3_q    <= hbS2_q;
      vbS3_q    <= vbS2_q;
    end
  end

  assign pal_dout = palDout_q;
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = hbS3_q;
  assign LVBL_dly = vbS3_q;

endmodule
